// File: rtl/sort_pkt_arbiter.sv
// Two-channel round-robin packet arbiter feeding the sorter.
// Forwards one whole packet per grant and truncates packets longer than 2**AWIDTH words.
module sort_pkt_arbiter #(
   parameter int unsigned AWIDTH = 3,
   parameter int unsigned DWIDTH = 8
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic [DWIDTH-1:0] data0_i,
   input  logic              sop0_i,
   input  logic              eop0_i,
   input  logic              val0_i,
   output logic              ready0_o,
   input  logic [DWIDTH-1:0] data1_i,
   input  logic              sop1_i,
   input  logic              eop1_i,
   input  logic              val1_i,
   output logic              ready1_o,
   input  logic              sort_busy_i,
   output logic [DWIDTH-1:0] data_o,
   output logic              sop_o,
   output logic              eop_o,
   output logic              val_o,
   output logic              trunc_o
);

   localparam int unsigned CW        = AWIDTH + 1;
   localparam int unsigned MAX_WORDS = 1 << AWIDTH;
   localparam logic [CW-1:0] MAX_LEN = CW'(MAX_WORDS);

   typedef enum logic [2:0] {IDLE, PASS, DROP, WAIT_BUSY, WAIT_DONE} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cnt, cnt_nxt, cnt_inc;
   logic              last_grant, last_grant_nxt;
   logic              ready0_nxt, ready1_nxt;
   logic [DWIDTH-1:0] data_nxt;
   logic              sop_nxt, eop_nxt, val_nxt, trunc_nxt;

   logic              req0, req1, gnt_c;
   logic [DWIDTH-1:0] g_data;
   logic              g_eop, g_acc;

   // Requests only come from a valid sop at the channel head; ties go against the last winner.
   assign req0    = val0_i && sop0_i;
   assign req1    = val1_i && sop1_i;
   assign gnt_c   = (req0 && req1) ? ~last_grant : req1;
   assign cnt_inc = cnt + CW'(1);

   // last_grant also selects the channel currently being forwarded.
   assign g_data = last_grant ? data1_i : data0_i;
   assign g_eop  = last_grant ? eop1_i  : eop0_i;
   assign g_acc  = last_grant ? (val1_i && ready1_o) : (val0_i && ready0_o);

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= 1'b1;
         ready0_o   <= 1'b0;
         ready1_o   <= 1'b0;
         data_o     <= '0;
         sop_o      <= 1'b0;
         eop_o      <= 1'b0;
         val_o      <= 1'b0;
         trunc_o    <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         last_grant <= last_grant_nxt;
         ready0_o   <= ready0_nxt;
         ready1_o   <= ready1_nxt;
         data_o     <= data_nxt;
         sop_o      <= sop_nxt;
         eop_o      <= eop_nxt;
         val_o      <= val_nxt;
         trunc_o    <= trunc_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      last_grant_nxt = last_grant;
      ready0_nxt     = ready0_o;
      ready1_nxt     = ready1_o;
      data_nxt       = data_o;
      sop_nxt        = 1'b0;
      eop_nxt        = 1'b0;
      val_nxt        = 1'b0;
      trunc_nxt      = 1'b0;

      case (state)
         IDLE: begin
            ready0_nxt = 1'b0;
            ready1_nxt = 1'b0;
            if (!sort_busy_i && (req0 || req1)) begin
               last_grant_nxt = gnt_c;
               ready0_nxt     = ~gnt_c;
               ready1_nxt     = gnt_c;
               state_nxt      = PASS;
            end
         end
         PASS: begin
            if (g_acc) begin
               data_nxt = g_data;
               val_nxt  = 1'b1;
               sop_nxt  = (cnt == '0);
               cnt_nxt  = cnt_inc;
               if (g_eop) begin
                  eop_nxt    = 1'b1;
                  ready0_nxt = 1'b0;
                  ready1_nxt = 1'b0;
                  state_nxt  = WAIT_BUSY;
               end else if (cnt_inc == MAX_LEN) begin
                  // Buffer full: close the packet here and swallow the remainder.
                  eop_nxt   = 1'b1;
                  trunc_nxt = 1'b1;
                  state_nxt = DROP;
               end
            end
         end
         DROP: begin
            if (g_acc && g_eop) begin
               ready0_nxt = 1'b0;
               ready1_nxt = 1'b0;
               state_nxt  = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            ready0_nxt = 1'b0;
            ready1_nxt = 1'b0;
            if (sort_busy_i) state_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            ready0_nxt = 1'b0;
            ready1_nxt = 1'b0;
            if (!sort_busy_i) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sort_pkt_arbiter.sv
// Bench for sort_pkt_arbiter: packet-level source/sorter models and a transfer-level
// reference that predicts grants, forwarded words, truncation and readys each cycle.
module tb_sort_pkt_arbiter;

   localparam int unsigned AWIDTH = 3;
   localparam int unsigned DWIDTH = 8;
   localparam int MAXW = 8;

   typedef struct packed {
      logic [DWIDTH-1:0] data;
      logic              sop;
      logic              eop;
   } word_t;

   logic              clk_i = 1'b0;
   logic              srst_i = 1'b1;
   logic [DWIDTH-1:0] data0_i = '0, data1_i = '0;
   logic              sop0_i = 1'b0, eop0_i = 1'b0, val0_i = 1'b0;
   logic              sop1_i = 1'b0, eop1_i = 1'b0, val1_i = 1'b0;
   logic              sort_busy_i = 1'b0;
   logic              ready0_o, ready1_o;
   logic [DWIDTH-1:0] data_o;
   logic              sop_o, eop_o, val_o, trunc_o;

   sort_pkt_arbiter #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) dut (
      .clk_i(clk_i), .srst_i(srst_i),
      .data0_i(data0_i), .sop0_i(sop0_i), .eop0_i(eop0_i), .val0_i(val0_i), .ready0_o(ready0_o),
      .data1_i(data1_i), .sop1_i(sop1_i), .eop1_i(eop1_i), .val1_i(val1_i), .ready1_o(ready1_o),
      .sort_busy_i(sort_busy_i),
      .data_o(data_o), .sop_o(sop_o), .eop_o(eop_o), .val_o(val_o), .trunc_o(trunc_o)
   );

   always #5 clk_i = ~clk_i;

   // Source queues, sorter busy schedule and reference state.
   word_t q0[$];
   word_t q1[$];
   bit    busy_q[$];
   bit    idle_busy = 1'b0;
   int    gap_pct = 0;
   bit    mr0 = 1'b0, mr1 = 1'b0;
   bit    in_pkt = 1'b0, arb_free = 1'b1, last_win = 1'b1, act = 1'b0;
   int    phase = 0;
   int    k = 0;
   int    total = 0;
   int    bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_pkt(input int ch, input int len, input int base, input bit rnd);
      word_t w;
      for (int i = 0; i < len; i++) begin
         w.data = rnd ? DWIDTH'($urandom) : DWIDTH'(base + i);
         w.sop  = (i == 0) || (rnd && ($urandom_range(9) == 0));
         w.eop  = (i == len - 1);
         if (ch == 0) q0.push_back(w);
         else         q1.push_back(w);
      end
   endtask

   // Source abandons the rest of an interrupted packet.
   task automatic drop_rest(input bit ch);
      word_t w;
      forever begin
         if (ch ? (q1.size() == 0) : (q0.size() == 0)) break;
         w = ch ? q1.pop_front() : q0.pop_front();
         if (w.eop) break;
      end
   endtask

   // One clock: drive at negedge, predict and check just after posedge.
   task automatic cyc(input bit rst);
      word_t w;
      bit busy_s, req0, req1, t, win;
      bit nr0, nr1;
      bit ev, es, ee, et;
      logic [DWIDTH-1:0] ed;
      @(negedge clk_i);
      srst_i = rst;
      if (q0.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
         w = q0[0]; val0_i = 1'b1; data0_i = w.data; sop0_i = w.sop; eop0_i = w.eop;
      end else begin
         val0_i = 1'b0; data0_i = DWIDTH'($urandom); sop0_i = 1'($urandom); eop0_i = 1'($urandom);
      end
      if (q1.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
         w = q1[0]; val1_i = 1'b1; data1_i = w.data; sop1_i = w.sop; eop1_i = w.eop;
      end else begin
         val1_i = 1'b0; data1_i = DWIDTH'($urandom); sop1_i = 1'($urandom); eop1_i = 1'($urandom);
      end
      busy_s = (busy_q.size() > 0) ? busy_q.pop_front() : idle_busy;
      sort_busy_i = busy_s;
      req0 = val0_i && sop0_i;
      req1 = val1_i && sop1_i;
      @(posedge clk_i);
      #1;
      ev = 1'b0; es = 1'b0; ee = 1'b0; et = 1'b0; ed = '0;
      if (rst) begin
         if (in_pkt) drop_rest(act);
         in_pkt = 1'b0; arb_free = 1'b1; last_win = 1'b1; phase = 0; k = 0;
         busy_q.delete();
      end else if (in_pkt) begin
         t = act ? (val1_i && mr1) : (val0_i && mr0);
         if (t) begin
            w = act ? q1.pop_front() : q0.pop_front();
            if (k < MAXW) begin
               ev = 1'b1; ed = w.data; es = (k == 0);
               ee = w.eop || (k == MAXW - 1);
               et = (k == MAXW - 1) && !w.eop;
            end
            k++;
            if (w.eop) begin
               in_pkt = 1'b0; phase = 1;
               repeat ($urandom_range(2)) busy_q.push_back(1'b0);
               repeat ($urandom_range(4, 1)) busy_q.push_back(1'b1);
            end
         end
      end else if (arb_free) begin
         if (!busy_s && (req0 || req1)) begin
            win = (req0 && req1) ? !last_win : req1;
            last_win = win; act = win; in_pkt = 1'b1; arb_free = 1'b0; k = 0;
         end
      end else if (phase == 1) begin
         if (busy_s) phase = 2;
      end else if (phase == 2) begin
         if (!busy_s) begin phase = 0; arb_free = 1'b1; end
      end
      nr0 = in_pkt && !act;
      nr1 = in_pkt && act;
      chk("val_o", 32'(val_o), 32'(ev));
      if (ev || rst) chk("data_o", 32'(data_o), 32'(ed));
      chk("sop_o", 32'(sop_o), 32'(es));
      chk("eop_o", 32'(eop_o), 32'(ee));
      chk("trunc_o", 32'(trunc_o), 32'(et));
      chk("ready0_o", 32'(ready0_o), 32'(nr0));
      chk("ready1_o", 32'(ready1_o), 32'(nr1));
      mr0 = nr0;
      mr1 = nr1;
   endtask

   task automatic run_done(input int budget);
      int n = 0;
      while (!(q0.size() == 0 && q1.size() == 0 && arb_free && !in_pkt && busy_q.size() == 0)
             && n < budget) begin
         cyc(1'b0);
         n++;
      end
      chk("drain_timeout", 32'(n >= budget), 32'd0);
   endtask

   initial begin
      int n;
      // Reset state
      cyc(1'b1);
      cyc(1'b1);
      cyc(1'b0);

      // Three-word packet on ch0
      push_pkt(0, 3, 'hA1, 1'b0);
      run_done(200);

      // Simultaneous requests after reset: ch0, then ch1, then ch0 again
      cyc(1'b1);
      push_pkt(0, 2, 'h10, 1'b0);
      push_pkt(1, 2, 'h20, 1'b0);
      run_done(200);
      push_pkt(0, 2, 'h30, 1'b0);
      push_pkt(1, 2, 'h40, 1'b0);
      run_done(200);

      // Eleven words on ch1: truncated to eight
      push_pkt(1, 11, 'h60, 1'b0);
      run_done(200);

      // Exactly eight words with eop: normal end
      push_pkt(0, 8, 'h80, 1'b0);
      run_done(200);

      // Single-word packet
      push_pkt(0, 1, 'h5A, 1'b0);
      run_done(200);

      // Sorter held busy while ch0 requests
      idle_busy = 1'b1;
      push_pkt(0, 3, 'hC0, 1'b0);
      repeat (5) cyc(1'b0);
      idle_busy = 1'b0;
      run_done(200);

      // Reset after two of five words, then a fresh ch1 packet
      push_pkt(0, 5, 'hD0, 1'b0);
      n = 0;
      while (!(in_pkt && k == 2) && n < 50) begin cyc(1'b0); n++; end
      chk("mid_pkt_timeout", 32'(n >= 50), 32'd0);
      cyc(1'b1);
      cyc(1'b0);
      push_pkt(1, 4, 'hE0, 1'b0);
      run_done(200);

      // Randomized traffic with bubbles, stray sops and varied lengths
      for (int p = 0; p < 15; p++) begin
         gap_pct = int'($urandom_range(40));
         push_pkt(0, int'($urandom_range(12, 1)), 0, 1'b1);
         if ($urandom_range(1) == 1) push_pkt(1, int'($urandom_range(12, 1)), 0, 1'b1);
         if ($urandom_range(2) == 0) push_pkt(1, int'($urandom_range(12, 1)), 0, 1'b1);
         if ($urandom_range(2) == 0) push_pkt(0, int'($urandom_range(12, 1)), 0, 1'b1);
         run_done(2000);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
